cap_timer_mc: RTL and testbench
===============================

# cap_timer_mc

Multi-channel programmable delay timer, the parametrised successor of the single-shot capture-delay counter in the Q_PROJECTION datapath. Each of `NUM_CH` independent channels is armed by a start strobe. It counts a per-start programmable number of cycles, then emits a one-cycle `done` pulse. Channels can run one-shot or periodic (auto-reload), can be cancelled, and can optionally be retriggered. Write-enable sequencing logic uses it to schedule capture and projection events.

## Interface
- `NUM_CH`, 4: number of independent channels (1..16).
- `CNT_W`, 8: counter and load-value width in bits.
- `DEFAULT_COUNT`, 10: terminal count used when `load_val` is 0; must satisfy 1 ≤ `DEFAULT_COUNT` ≤ 2^CNT_W−1.
- `RETRIGGER`, 0: 1 = a start on an active channel restarts it; 0 = the start is ignored and flagged.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  NUM_CH: per-channel arm strobe, sampled each edge.
- `stop`  in  NUM_CH: per-channel cancel strobe.
- `periodic`  in  NUM_CH: mode, sampled with `start`. 1 = auto-reload, 0 = one-shot.
- `load_val`  in  NUM_CH*CNT_W: per-channel terminal count. Channel i uses bits [i*CNT_W +: CNT_W], captured on an accepted start.
- `busy`  out  NUM_CH: channel active.
- `done`  out  NUM_CH: one-cycle terminal pulse.
- `count`  out  NUM_CH*CNT_W: per-channel current count.
- `ovr`  out  NUM_CH: sticky flag for a start ignored while busy.
- `done_any`  out  1: OR of `done`, registered in the same cycle as `done`.

## Operation
- Per-channel state: `active`, count `cnt`, latched terminal `N`, latched `mode`, `done`, `ovr`. Channels are fully independent.
- Reset (`rst_n`=0, async) clears every output and internal register to 0 immediately. Outputs stay 0 until the first accepted start.
- Per-channel priority each edge: stop > start > count.
- **Stop.** `active`←0. `cnt` holds its value. `done`←0. `ovr`←0. A simultaneous start is discarded.
- **Accepted start** (idle, or active with `RETRIGGER`=1):
  - `active`←1 and `cnt`←0.
  - `N`←`load_val` slice, or `DEFAULT_COUNT` if the slice is 0.
  - `mode`←`periodic[i]`, `done`←0.
- **Start while active with `RETRIGGER`=0.** Ignored: `ovr`←1, and counting continues unaffected.
- **Count step while active:**
  - If `cnt` < N−1: `cnt`←`cnt`+1 and `done`←0.
  - Terminal (`cnt` = N−1), one-shot: `cnt`←N, `active`←0, `done`←1.
  - Terminal (`cnt` = N−1), periodic: `cnt`←0, `active` stays 1, `done`←1.
- **Idle channel.** `done`←0. `cnt` holds its last value: N after a one-shot completes, or the value at stop.
- **Retrigger on the terminal cycle** (`RETRIGGER`=1). The restart wins and no `done` is emitted.
- **Start on the terminal cycle** (`RETRIGGER`=0). The terminal completes normally, `done` is emitted, and `ovr` is set.
- **Width.** `cnt` never exceeds N ≤ 2^CNT_W−1, so it cannot wrap.
- **Tie-offs.** `busy` = `active`. `done_any`←OR of the next-state `done` vector.

## Timing
- Start sampled at edge T gives `busy`=1 and `cnt`=0 after T, and `cnt`=k after edge T+k.
- One-shot: `done`=1 for exactly the cycle following edge T+N, with `busy`=0 in that same cycle. Latency start→done is N cycles.
- Periodic: `done` pulses after edges T+N, T+2N, …, one cycle each. `busy` stays 1 throughout.
- N=1: `done` is asserted after edge T+1, and `cnt` shows 0 for a single cycle.
- A new start can be accepted on the same edge at which `done` is asserted (idle by then). Back-to-back one-shots are therefore spaced N+1 starts apart minimum, one idle cycle between.
- Stop at edge S: `busy`=0 after S, with no `done` at or after S.
- Reset mid-count: all outputs are 0 asynchronously. The first edge after `rst_n` rises behaves as idle.

## Test plan
- **One-shot, default count.** Ch0: start with `load_val`=0 and `periodic`=0 → `count` steps 0..9, `done[0]` and `done_any` high for one cycle 10 cycles after start, `busy` drops on the same cycle, and `count` holds 10.
- **Periodic with stop.** Ch1: `load_val`=3, `periodic`=1 → `done[1]` pulses every 3 cycles for 4 periods. Stop mid-period → `busy`=0, no further `done`, `count` frozen.
- **Retrigger, `RETRIGGER`=0.** Ch2: `load_val`=5, second start at `cnt`=2 → `ovr[2]`=1, `done` still 5 cycles after the first start. A later stop clears `ovr`.
- **Retrigger, `RETRIGGER`=1.** Same stimulus → `cnt` returns to 0 and `done` arrives 5 cycles after the second start. A start exactly on the terminal cycle → no `done`, count restarts.
- **Channel independence.** Start all channels on the same edge with `load_val` = 1, 2, 255, 4 → each `done` arrives at its own N, with no cross-talk. The N=255 channel reaches `count`=255 without wrapping.
- **Async reset and priority.** Assert `rst_n`=0 mid-count between edges → all outputs 0 immediately, no `done` after release. Simultaneous start+stop on an idle channel → it stays idle.

Source files
------------

// File: rtl/cap_timer_mc_if.sv
// Bundle of the per-channel control strobes and status outputs of cap_timer_mc.
//   master: drives start/stop/periodic/load_val, observes busy/done/count/ovr/done_any
//   slave : the timer itself
// Channel i of a flattened vector lives at [i*CNT_W +: CNT_W].
interface cap_timer_mc_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
);
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       periodic;
  logic [NUM_CH*CNT_W-1:0] load_val;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       ovr;
  logic                    done_any;

  modport master (
    output start, stop, periodic, load_val,
    input  busy, done, count, ovr, done_any
  );

  modport slave (
    input  start, stop, periodic, load_val,
    output busy, done, count, ovr, done_any
  );
endinterface

// File: rtl/cap_timer_mc.sv
// Multi-channel programmable delay timer.
// Each channel is armed by start, counts N cycles (N = load_val slice, or DEFAULT_COUNT when the
// slice is 0) and emits a one-cycle done pulse. One-shot or periodic (auto-reload) per start;
// stop cancels; with RETRIGGER=1 a start on a running channel restarts it, otherwise it is
// ignored and the sticky ovr flag is raised.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   ctl_io : cap_timer_mc_if.slave (start/stop/periodic/load_val in; busy/done/count/ovr/done_any
//            out), all outputs registered.
module cap_timer_mc #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned DEFAULT_COUNT = 10,
  parameter bit          RETRIGGER     = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  cap_timer_mc_if.slave  ctl_io
);

  localparam logic [CNT_W-1:0] DefCnt = CNT_W'(DEFAULT_COUNT);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  typedef enum logic {StIdle, StRun} ch_state_e;

  ch_state_e state_q [NUM_CH];
  ch_state_e state_d [NUM_CH];

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] term_q, term_d;
  logic [NUM_CH-1:0][CNT_W-1:0] load_slice;
  logic [NUM_CH-1:0]            mode_q, mode_d;
  logic [NUM_CH-1:0]            done_q, done_d;
  logic [NUM_CH-1:0]            ovr_q, ovr_d;
  logic [NUM_CH-1:0]            accept;
  logic [NUM_CH-1:0]            active;
  logic                         done_any_q, done_any_d;

  assign load_slice = ctl_io.load_val;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      term_d[i]  = term_q[i];
      mode_d[i]  = mode_q[i];
      done_d[i]  = 1'b0;
      ovr_d[i]   = ovr_q[i];
      active[i]  = (state_q[i] == StRun);
      accept[i]  = ctl_io.start[i] && (!active[i] || RETRIGGER);

      if (ctl_io.stop[i]) begin
        // Cancel: count freezes where it is, any coincident start is dropped.
        state_d[i] = StIdle;
        ovr_d[i]   = 1'b0;
      end else if (accept[i]) begin
        // A restart on the terminal cycle wins, so no done is produced.
        state_d[i] = StRun;
        cnt_d[i]   = '0;
        term_d[i]  = (load_slice[i] == '0) ? DefCnt : load_slice[i];
        mode_d[i]  = ctl_io.periodic[i];
      end else begin
        if (ctl_io.start[i] && active[i]) begin
          ovr_d[i] = 1'b1;
        end
        if (active[i]) begin
          if (cnt_q[i] < term_q[i] - One) begin
            cnt_d[i] = cnt_q[i] + One;
          end else begin
            done_d[i] = 1'b1;
            if (mode_q[i]) begin
              cnt_d[i] = '0;
            end else begin
              cnt_d[i]   = term_q[i];
              state_d[i] = StIdle;
            end
          end
        end
      end
    end
    done_any_d = |done_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= StIdle;
      end
      cnt_q      <= '0;
      term_q     <= '0;
      mode_q     <= '0;
      done_q     <= '0;
      ovr_q      <= '0;
      done_any_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
      end
      cnt_q      <= cnt_d;
      term_q     <= term_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      done_any_q <= done_any_d;
    end
  end

  assign ctl_io.busy     = active;
  assign ctl_io.done     = done_q;
  assign ctl_io.count    = cnt_q;
  assign ctl_io.ovr      = ovr_q;
  assign ctl_io.done_any = done_any_q;

endmodule

// File: tb/tb_cap_timer_mc.sv
// Bench for cap_timer_mc: u0 has RETRIGGER=0, u1 has RETRIGGER=1. Expected done pulses are pushed
// to a scoreboard when a start is driven and compared every cycle by a negedge monitor; status
// outputs are checked at directed points 1 time unit after the clock edge.
`timescale 1ns/1ps
module tb_cap_timer_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cap_timer_mc_if #(.NUM_CH(4), .CNT_W(8)) if0 ();
  cap_timer_mc_if #(.NUM_CH(4), .CNT_W(8)) if1 ();

  cap_timer_mc #(.NUM_CH(4), .CNT_W(8), .DEFAULT_COUNT(10), .RETRIGGER(1'b0)) u0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctl_io (if0)
  );

  cap_timer_mc #(.NUM_CH(4), .CNT_W(8), .DEFAULT_COUNT(10), .RETRIGGER(1'b1)) u1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctl_io (if1)
  );

  typedef struct {
    int inst;
    int ch;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Done scoreboard: every cycle, the done vector must match exactly the entries due now.
  always @(negedge clk) begin : mon
    logic [3:0] exp0;
    logic [3:0] exp1;
    exp0 = '0;
    exp1 = '0;
    for (int k = sb_q.size() - 1; k >= 0; k--) begin
      if (sb_q[k].cyc == cyc) begin
        if (sb_q[k].inst == 0) exp0[sb_q[k].ch] = 1'b1;
        else exp1[sb_q[k].ch] = 1'b1;
        sb_q.delete(k);
      end
    end
    n_checks += 4;
    assert (if0.done === exp0) else begin
      n_err++;
      $error("FAIL done0 cyc %0d: observed %b expected %b", cyc, if0.done, exp0);
    end
    assert (if0.done_any === (|exp0)) else begin
      n_err++;
      $error("FAIL done_any0 cyc %0d: observed %b expected %b", cyc, if0.done_any, |exp0);
    end
    assert (if1.done === exp1) else begin
      n_err++;
      $error("FAIL done1 cyc %0d: observed %b expected %b", cyc, if1.done, exp1);
    end
    assert (if1.done_any === (|exp1)) else begin
      n_err++;
      $error("FAIL done_any1 cyc %0d: observed %b expected %b", cyc, if1.done_any, |exp1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arm a channel for the next edge and schedule its expected done pulses.
  task automatic arm(input int inst, input int ch, input logic [7:0] lv, input logic per,
                     input int nper);
    int n;
    n = (lv == 8'd0) ? 10 : int'(lv);
    if (inst == 0) begin
      if0.start[ch] = 1'b1;
      if0.periodic[ch] = per;
      if0.load_val[ch*8 +: 8] = lv;
    end else begin
      if1.start[ch] = 1'b1;
      if1.periodic[ch] = per;
      if1.load_val[ch*8 +: 8] = lv;
    end
    for (int p = 1; p <= nper; p++) sb_q.push_back('{inst, ch, cyc + 1 + n * p});
  endtask

  function automatic void drop(input int inst, input int ch);
    for (int k = sb_q.size() - 1; k >= 0; k--) begin
      if (sb_q[k].inst == inst && sb_q[k].ch == ch) sb_q.delete(k);
    end
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if0.start = '0;
      if0.stop = '0;
      if1.start = '0;
      if1.stop = '0;
    end
  endtask

  function automatic logic [7:0] cnt0(input int ch);
    return if0.count[ch*8 +: 8];
  endfunction

  function automatic logic [7:0] cnt1(input int ch);
    return if1.count[ch*8 +: 8];
  endfunction

  initial begin
    if0.start = '0; if0.stop = '0; if0.periodic = '0; if0.load_val = '0;
    if1.start = '0; if1.stop = '0; if1.periodic = '0; if1.load_val = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(if0.busy), 32'h0);
    chk("rst_count", if0.count, 32'h0);
    chk("rst_ovr", 32'(if0.ovr), 32'h0);
    chk("rst_done_any", 32'(if0.done_any), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);

    // One-shot, default count on ch0.
    arm(0, 0, 8'd0, 1'b0, 1);
    tick(1);
    chk("os_busy_start", 32'(if0.busy[0]), 32'h1);
    chk("os_cnt0", 32'(cnt0(0)), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      chk("os_cnt_step", 32'(cnt0(0)), 32'(k));
    end
    tick(1);
    chk("os_cnt_term", 32'(cnt0(0)), 32'd10);
    chk("os_busy_term", 32'(if0.busy[0]), 32'h0);
    tick(2);
    chk("os_cnt_hold", 32'(cnt0(0)), 32'd10);

    // Periodic N=3 on ch1, four periods, then stop mid-period.
    arm(0, 1, 8'd3, 1'b1, 4);
    tick(14);
    chk("per_busy", 32'(if0.busy[1]), 32'h1);
    chk("per_cnt", 32'(cnt0(1)), 32'd1);
    if0.stop[1] = 1'b1;
    tick(1);
    chk("per_stop_busy", 32'(if0.busy[1]), 32'h0);
    chk("per_stop_cnt", 32'(cnt0(1)), 32'd1);
    tick(5);
    chk("per_frozen", 32'(cnt0(1)), 32'd1);

    // RETRIGGER=0: second start at cnt=2 is ignored and flagged.
    arm(0, 2, 8'd5, 1'b0, 1);
    tick(3);
    chk("nr_cnt2", 32'(cnt0(2)), 32'd2);
    if0.start[2] = 1'b1;
    tick(1);
    chk("nr_ovr", 32'(if0.ovr[2]), 32'h1);
    chk("nr_cnt3", 32'(cnt0(2)), 32'd3);
    tick(2);
    chk("nr_cnt_term", 32'(cnt0(2)), 32'd5);
    chk("nr_busy_term", 32'(if0.busy[2]), 32'h0);
    chk("nr_ovr_sticky", 32'(if0.ovr[2]), 32'h1);
    if0.stop[2] = 1'b1;
    tick(1);
    chk("nr_ovr_clr", 32'(if0.ovr[2]), 32'h0);
    // Start on the terminal cycle: done still fires, ovr set.
    arm(0, 2, 8'd2, 1'b0, 1);
    tick(2);
    if0.start[2] = 1'b1;
    tick(1);
    chk("nr_term_ovr", 32'(if0.ovr[2]), 32'h1);
    chk("nr_term_busy", 32'(if0.busy[2]), 32'h0);
    chk("nr_term_cnt", 32'(cnt0(2)), 32'd2);

    // RETRIGGER=1: second start restarts the count.
    arm(1, 2, 8'd5, 1'b0, 1);
    tick(3);
    drop(1, 2);
    arm(1, 2, 8'd5, 1'b0, 1);
    tick(1);
    chk("rt_cnt0", 32'(cnt1(2)), 32'd0);
    chk("rt_busy", 32'(if1.busy[2]), 32'h1);
    chk("rt_ovr", 32'(if1.ovr[2]), 32'h0);
    tick(5);
    chk("rt_cnt_term", 32'(cnt1(2)), 32'd5);
    chk("rt_busy_term", 32'(if1.busy[2]), 32'h0);
    // Retrigger exactly on the terminal cycle: no done, count restarts.
    arm(1, 3, 8'd3, 1'b0, 1);
    tick(3);
    drop(1, 3);
    arm(1, 3, 8'd3, 1'b0, 1);
    tick(1);
    chk("rt_term_cnt", 32'(cnt1(3)), 32'd0);
    chk("rt_term_busy", 32'(if1.busy[3]), 32'h1);
    tick(3);
    chk("rt_term_done_cnt", 32'(cnt1(3)), 32'd3);

    // Channel independence, N = 1, 2, 255, 4 on the same edge.
    arm(0, 0, 8'd1, 1'b0, 1);
    arm(0, 1, 8'd2, 1'b0, 1);
    arm(0, 2, 8'd255, 1'b0, 1);
    arm(0, 3, 8'd4, 1'b0, 1);
    tick(1);
    chk("ind_busy", 32'(if0.busy), 32'hf);
    chk("ind_count", if0.count, 32'h0);
    tick(1);
    chk("ind_n1_busy", 32'(if0.busy), 32'he);
    chk("ind_n1_cnt", 32'(cnt0(0)), 32'd1);
    tick(3);
    chk("ind_n4_cnt", 32'(cnt0(3)), 32'd4);
    chk("ind_n4_busy", 32'(if0.busy), 32'h4);
    tick(250);
    chk("ind_n255_cnt254", 32'(cnt0(2)), 32'd254);
    tick(1);
    chk("ind_n255_cnt", 32'(cnt0(2)), 32'd255);
    chk("ind_n255_busy", 32'(if0.busy), 32'h0);
    tick(2);
    chk("ind_n255_hold", 32'(cnt0(2)), 32'd255);

    // Asynchronous reset between edges mid-count.
    arm(0, 0, 8'd10, 1'b0, 1);
    tick(4);
    #2 rst_n = 1'b0;
    drop(0, 0);
    #1;
    chk("arst_busy", 32'(if0.busy), 32'h0);
    chk("arst_count", if0.count, 32'h0);
    chk("arst_done_any", 32'(if0.done_any), 32'h0);
    chk("arst_ovr", 32'(if0.ovr), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(15);
    chk("arst_idle", 32'(if0.busy), 32'h0);

    // Simultaneous start+stop on an idle channel: stays idle.
    if0.start[1] = 1'b1;
    if0.stop[1] = 1'b1;
    if0.load_val[15:8] = 8'd3;
    tick(1);
    chk("ss_busy", 32'(if0.busy[1]), 32'h0);
    chk("ss_cnt", 32'(cnt0(1)), 32'd0);
    tick(12);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
